csr_trap_sequencer: RTL and testbench

- Supervisor trap-entry and SRET controller that owns the CSR file's single write port (data/select/load).
- On a trap, it sequences the sepc, scause, stval and sstatus updates one per cycle, then issues a PC redirect to stvec.
- On SRET, it restores sstatus and redirects to sepc.
- Outside a sequence, it forwards the instruction path's CSR writes (csrrw/csrrs/csrrc) to the CSR file unchanged.

---
 rtl/csr_pkg.sv | 47 ++++
 rtl/csr_trap_sequencer_if.sv | 42 ++++
 rtl/csr_trap_target.sv | 24 ++
 rtl/csr_trap_sequencer.sv | 115 +++++++++++
 tb/tb_csr_trap_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared CSR definitions for the supervisor trap/SRET sequencer: addresses,
// sstatus bit positions, sequencer states and the sstatus rewrite helpers.
package csr_pkg;

  localparam logic [11:0] CSR_SSTATUS = 12'h100;
  localparam logic [11:0] CSR_STVEC   = 12'h105;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_STVAL   = 12'h143;
  localparam logic [11:0] CSR_SIP     = 12'h144;

  localparam int SSTATUS_SIE  = 1;
  localparam int SSTATUS_SPIE = 5;
  localparam int SSTATUS_SPP  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_SEPC,
    S_W_SCAUSE,
    S_W_STVAL,
    S_W_SSTATUS,
    S_SRET_STATUS,
    S_REDIRECT
  } seq_state_t;

  // Trap entry: stash SIE into SPIE, disable interrupts, record previous privilege.
  function automatic logic [31:0] trap_sstatus(input logic [31:0] sstatus,
                                               input logic        from_s);
    logic [31:0] v;
    v               = sstatus;
    v[SSTATUS_SPIE] = sstatus[SSTATUS_SIE];
    v[SSTATUS_SIE]  = 1'b0;
    v[SSTATUS_SPP]  = from_s;
    return v;
  endfunction

  // SRET: restore SIE from SPIE, re-arm SPIE, drop back to U in SPP.
  function automatic logic [31:0] sret_sstatus(input logic [31:0] sstatus);
    logic [31:0] v;
    v               = sstatus;
    v[SSTATUS_SIE]  = sstatus[SSTATUS_SPIE];
    v[SSTATUS_SPIE] = 1'b1;
    v[SSTATUS_SPP]  = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/csr_trap_sequencer_if.sv
// Bundle between the pipeline/CSR file and the trap sequencer. The pipeline side
// (master) drives requests and current CSR values; the sequencer (slave) drives the write port.
interface csr_trap_sequencer_if;

  logic        i_trap_req;
  logic [31:0] i_trap_cause;
  logic [31:0] i_trap_pc;
  logic [31:0] i_trap_tval;
  logic        i_trap_from_s;
  logic        i_sret_req;
  logic [31:0] i_sstatus;
  logic [31:0] i_stvec;
  logic [31:0] i_sepc;
  logic        i_instr_csr_load;
  logic [11:0] i_instr_csr_select;
  logic [31:0] i_instr_csr_data;

  logic        o_csr_load;
  logic [11:0] o_csr_select;
  logic [31:0] o_csr_data;
  logic        o_ack;
  logic        o_busy;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;

  modport master (
    output i_trap_req, i_trap_cause, i_trap_pc, i_trap_tval, i_trap_from_s,
           i_sret_req, i_sstatus, i_stvec, i_sepc,
           i_instr_csr_load, i_instr_csr_select, i_instr_csr_data,
    input  o_csr_load, o_csr_select, o_csr_data, o_ack, o_busy,
           o_redirect_valid, o_redirect_pc
  );

  modport slave (
    input  i_trap_req, i_trap_cause, i_trap_pc, i_trap_tval, i_trap_from_s,
           i_sret_req, i_sstatus, i_stvec, i_sepc,
           i_instr_csr_load, i_instr_csr_select, i_instr_csr_data,
    output o_csr_load, o_csr_select, o_csr_data, o_ack, o_busy,
           o_redirect_valid, o_redirect_pc
  );

endinterface

// File: rtl/csr_trap_target.sv
// Trap target PC from stvec and scause: direct mode goes to BASE, vectored
// mode sends interrupts to BASE + 4*cause. MODE values 2/3 behave as direct.
module csr_trap_target #(
  parameter bit P_VECTORED_EN = 1'b1
) (
  input  logic [31:0] i_stvec,
  input  logic [31:0] i_cause,
  output logic [31:0] o_target
);

  logic [31:0] w_base;
  logic [31:0] w_offset;
  logic        w_vectored;
  logic        w_unused_cause_bit;

  assign w_base     = {i_stvec[31:2], 2'b00};
  // cause[30] lands beyond bit 31 after the <<2 and wraps away.
  assign w_offset   = {i_cause[29:0], 2'b00};
  assign w_vectored = P_VECTORED_EN && (i_stvec[1:0] == 2'b01) && i_cause[31];
  assign o_target   = w_vectored ? (w_base + w_offset) : w_base;

  assign w_unused_cause_bit = i_cause[30];

endmodule

// File: rtl/csr_trap_sequencer.sv
// Supervisor trap-entry / SRET sequencer owning the CSR file's single write port.
// State and captured trap data are registered; the write port is a mux on state.
module csr_trap_sequencer
  import csr_pkg::*;
#(
  parameter bit P_VECTORED_EN = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  csr_trap_sequencer_if.slave  bus
);

  seq_state_t  r_state;
  logic [31:0] r_cause;
  logic [31:0] r_pc;
  logic [31:0] r_tval;
  logic        r_from_s;
  logic        r_is_sret;
  logic [31:0] w_trap_target;

  csr_trap_target #(
    .P_VECTORED_EN (P_VECTORED_EN)
  ) u_target (
    .i_stvec  (bus.i_stvec),
    .i_cause  (r_cause),
    .o_target (w_trap_target)
  );

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cause   <= '0;
      r_pc      <= '0;
      r_tval    <= '0;
      r_from_s  <= 1'b0;
      r_is_sret <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.i_trap_req) begin
            r_cause   <= bus.i_trap_cause;
            r_pc      <= bus.i_trap_pc;
            r_tval    <= bus.i_trap_tval;
            r_from_s  <= bus.i_trap_from_s;
            r_is_sret <= 1'b0;
            r_state   <= S_W_SEPC;
          end else if (bus.i_sret_req) begin
            r_is_sret <= 1'b1;
            r_state   <= S_SRET_STATUS;
          end
        end
        S_W_SEPC:      r_state <= S_W_SCAUSE;
        S_W_SCAUSE:    r_state <= S_W_STVAL;
        S_W_STVAL:     r_state <= S_W_SSTATUS;
        S_W_SSTATUS:   r_state <= S_REDIRECT;
        S_SRET_STATUS: r_state <= S_REDIRECT;
        S_REDIRECT:    r_state <= S_IDLE;
        default:       r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    bus.o_csr_load       = 1'b0;
    bus.o_csr_select     = '0;
    bus.o_csr_data       = '0;
    bus.o_ack            = 1'b0;
    bus.o_busy           = 1'b1;
    bus.o_redirect_valid = 1'b0;
    bus.o_redirect_pc    = '0;
    unique case (r_state)
      S_IDLE: begin
        // The instruction path keeps the port in IDLE, acceptance cycle included.
        bus.o_busy       = 1'b0;
        bus.o_csr_load   = bus.i_instr_csr_load;
        bus.o_csr_select = bus.i_instr_csr_select;
        bus.o_csr_data   = bus.i_instr_csr_data;
        bus.o_ack        = !i_rst && (bus.i_trap_req || bus.i_sret_req);
      end
      S_W_SEPC: begin
        bus.o_csr_load   = 1'b1;
        bus.o_csr_select = CSR_SEPC;
        bus.o_csr_data   = r_pc;
      end
      S_W_SCAUSE: begin
        bus.o_csr_load   = 1'b1;
        bus.o_csr_select = CSR_SCAUSE;
        bus.o_csr_data   = r_cause;
      end
      S_W_STVAL: begin
        bus.o_csr_load   = 1'b1;
        bus.o_csr_select = CSR_STVAL;
        bus.o_csr_data   = r_tval;
      end
      S_W_SSTATUS: begin
        bus.o_csr_load   = 1'b1;
        bus.o_csr_select = CSR_SSTATUS;
        bus.o_csr_data   = trap_sstatus(bus.i_sstatus, r_from_s);
      end
      S_SRET_STATUS: begin
        bus.o_csr_load   = 1'b1;
        bus.o_csr_select = CSR_SSTATUS;
        bus.o_csr_data   = sret_sstatus(bus.i_sstatus);
      end
      S_REDIRECT: begin
        bus.o_redirect_valid = 1'b1;
        bus.o_redirect_pc    = r_is_sret ? {bus.i_sepc[31:1], 1'b0} : w_trap_target;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed bench for csr_trap_sequencer: a vectored and a direct-only instance
// see identical stimulus; expected values are hand-computed constants.
module tb_csr_trap_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        trap_req, trap_from_s, sret_req, instr_load;
  logic [31:0] trap_cause, trap_pc, trap_tval, sstatus, stvec, sepc, instr_data;
  logic [11:0] instr_sel;

  int n_checks = 0;
  int n_fail   = 0;

  csr_trap_sequencer_if bus_v ();
  csr_trap_sequencer_if bus_d ();

  assign bus_v.i_trap_req = trap_req;           assign bus_d.i_trap_req = trap_req;
  assign bus_v.i_trap_cause = trap_cause;       assign bus_d.i_trap_cause = trap_cause;
  assign bus_v.i_trap_pc = trap_pc;             assign bus_d.i_trap_pc = trap_pc;
  assign bus_v.i_trap_tval = trap_tval;         assign bus_d.i_trap_tval = trap_tval;
  assign bus_v.i_trap_from_s = trap_from_s;     assign bus_d.i_trap_from_s = trap_from_s;
  assign bus_v.i_sret_req = sret_req;           assign bus_d.i_sret_req = sret_req;
  assign bus_v.i_sstatus = sstatus;             assign bus_d.i_sstatus = sstatus;
  assign bus_v.i_stvec = stvec;                 assign bus_d.i_stvec = stvec;
  assign bus_v.i_sepc = sepc;                   assign bus_d.i_sepc = sepc;
  assign bus_v.i_instr_csr_load = instr_load;   assign bus_d.i_instr_csr_load = instr_load;
  assign bus_v.i_instr_csr_select = instr_sel;  assign bus_d.i_instr_csr_select = instr_sel;
  assign bus_v.i_instr_csr_data = instr_data;   assign bus_d.i_instr_csr_data = instr_data;

  csr_trap_sequencer #(.P_VECTORED_EN(1'b1)) dut_v (.i_clk(clk), .i_rst(rst), .bus(bus_v));
  csr_trap_sequencer #(.P_VECTORED_EN(1'b0)) dut_d (.i_clk(clk), .i_rst(rst), .bus(bus_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Trap from IDLE; checks the ack cycle, four writes, redirect and return to IDLE.
  task automatic run_trap(input string tag, input logic [31:0] cause, pc, tval,
                          input logic from_s, input logic [31:0] ss, tv,
                          input logic [31:0] exp_ss, exp_v, exp_d);
    logic [11:0] es [4];
    logic [31:0] ed [4];
    es = '{12'h141, 12'h142, 12'h143, 12'h100};
    ed = '{pc, cause, tval, exp_ss};
    trap_req = 1'b1; trap_cause = cause; trap_pc = pc; trap_tval = tval;
    trap_from_s = from_s; sstatus = ss; stvec = tv;
    settle();
    n_checks++; if (bus_v.o_ack !== 1'b1) begin n_fail++; $display("FAIL %s ack0 got=%b exp=1", tag, bus_v.o_ack); end
    n_checks++; if (bus_v.o_busy !== 1'b0) begin n_fail++; $display("FAIL %s busy0 got=%b exp=0", tag, bus_v.o_busy); end
    tick();
    trap_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_checks++; if (bus_v.o_csr_load !== 1'b1) begin n_fail++; $display("FAIL %s load c%0d got=%b exp=1", tag, k+1, bus_v.o_csr_load); end
      n_checks++; if (bus_v.o_csr_select !== es[k]) begin n_fail++; $display("FAIL %s sel c%0d got=%h exp=%h", tag, k+1, bus_v.o_csr_select, es[k]); end
      n_checks++; if (bus_v.o_csr_data !== ed[k]) begin n_fail++; $display("FAIL %s data c%0d got=%h exp=%h", tag, k+1, bus_v.o_csr_data, ed[k]); end
      n_checks++; if (bus_v.o_busy !== 1'b1 || bus_v.o_ack !== 1'b0) begin n_fail++; $display("FAIL %s busy/ack c%0d got=%b/%b exp=1/0", tag, k+1, bus_v.o_busy, bus_v.o_ack); end
      tick();
    end
    settle();
    n_checks++; if (bus_v.o_redirect_valid !== 1'b1) begin n_fail++; $display("FAIL %s rv c5 got=%b exp=1", tag, bus_v.o_redirect_valid); end
    n_checks++; if (bus_v.o_redirect_pc !== exp_v) begin n_fail++; $display("FAIL %s rpc_vec got=%h exp=%h", tag, bus_v.o_redirect_pc, exp_v); end
    n_checks++; if (bus_d.o_redirect_pc !== exp_d) begin n_fail++; $display("FAIL %s rpc_dir got=%h exp=%h", tag, bus_d.o_redirect_pc, exp_d); end
    n_checks++; if (bus_v.o_csr_load !== 1'b0) begin n_fail++; $display("FAIL %s load c5 got=%b exp=0", tag, bus_v.o_csr_load); end
    tick();
    settle();
    n_checks++; if (bus_v.o_busy !== 1'b0 || bus_v.o_redirect_valid !== 1'b0) begin n_fail++; $display("FAIL %s idle c6 busy/rv got=%b/%b exp=0/0", tag, bus_v.o_busy, bus_v.o_redirect_valid); end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; trap_req = 1'b1; sret_req = 1'b0; trap_from_s = 1'b0;
    trap_cause = 32'h5; trap_pc = 32'h100; trap_tval = '0;
    sstatus = '0; stvec = 32'h80000100; sepc = '0;
    instr_load = 1'b0; instr_sel = '0; instr_data = '0;
    tick(); tick();
    settle();
    n_checks++; if (bus_v.o_ack !== 1'b0) begin n_fail++; $display("FAIL reset ack_in_rst got=%b exp=0", bus_v.o_ack); end
    tick();
    rst = 1'b0; trap_req = 1'b0;
    settle();
    n_checks++; if (bus_v.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got=%b exp=0", bus_v.o_busy); end
    n_checks++; if (bus_v.o_csr_load !== 1'b0) begin n_fail++; $display("FAIL reset load got=%b exp=0", bus_v.o_csr_load); end
    n_checks++; if (bus_v.o_redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset rv got=%b exp=0", bus_v.o_redirect_valid); end
    n_checks++; if (bus_v.o_redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset rpc got=%h exp=0", bus_v.o_redirect_pc); end
    n_checks++; if (bus_v.o_ack !== 1'b0) begin n_fail++; $display("FAIL reset ack got=%b exp=0", bus_v.o_ack); end
    tick();
    instr_load = 1'b1; instr_sel = 12'h180; instr_data = 32'h00001234;
    settle();
    n_checks++; if ({bus_v.o_csr_load, bus_v.o_csr_select, bus_v.o_csr_data} !== {1'b1, 12'h180, 32'h00001234}) begin
      n_fail++; $display("FAIL idle_mirror got=%b/%h/%h exp=1/180/00001234", bus_v.o_csr_load, bus_v.o_csr_select, bus_v.o_csr_data); end
    tick();
    instr_load = 1'b0;
  endtask

  task automatic test_trap_direct();
    run_trap("trap_exc", 32'h0000000D, 32'h80001234, 32'hDEADBEEF, 1'b0,
             32'h00000002, 32'h80000100, 32'h00000020, 32'h80000100, 32'h80000100);
    run_trap("trap_from_s", 32'h0000000C, 32'h80004000, 32'h00000010, 1'b1,
             32'h00000020, 32'h80000100, 32'h00000100, 32'h80000100, 32'h80000100);
  endtask

  task automatic test_vectored();
    run_trap("vec_irq", 32'h80000005, 32'h80000200, 32'h0, 1'b0,
             32'h00000002, 32'h80000101, 32'h00000020, 32'h80000114, 32'h80000100);
    run_trap("vec_exc", 32'h00000005, 32'h80000200, 32'h0, 1'b0,
             32'h00000000, 32'h80000101, 32'h00000000, 32'h80000100, 32'h80000100);
    run_trap("mode3_direct", 32'h80000009, 32'h80000300, 32'h0, 1'b0,
             32'h00000000, 32'h80000103, 32'h00000000, 32'h80000100, 32'h80000100);
    run_trap("vec_wrap", 32'h80000010, 32'h00000000, 32'h0, 1'b0,
             32'h00000000, 32'hFFFFFFC1, 32'h00000000, 32'h00000000, 32'hFFFFFFC0);
  endtask

  task automatic test_sret();
    sret_req = 1'b1; sstatus = 32'h00000120; sepc = 32'h80002003;
    settle();
    n_checks++; if (bus_v.o_ack !== 1'b1) begin n_fail++; $display("FAIL sret ack got=%b exp=1", bus_v.o_ack); end
    tick();
    sret_req = 1'b0;
    settle();
    n_checks++; if ({bus_v.o_csr_load, bus_v.o_csr_select, bus_v.o_csr_data} !== {1'b1, 12'h100, 32'h00000022}) begin
      n_fail++; $display("FAIL sret write got=%b/%h/%h exp=1/100/00000022", bus_v.o_csr_load, bus_v.o_csr_select, bus_v.o_csr_data); end
    tick();
    settle();
    n_checks++; if (bus_v.o_redirect_valid !== 1'b1 || bus_v.o_redirect_pc !== 32'h80002002) begin
      n_fail++; $display("FAIL sret redirect got=%b/%h exp=1/80002002", bus_v.o_redirect_valid, bus_v.o_redirect_pc); end
    tick();
    settle();
    n_checks++; if (bus_v.o_busy !== 1'b0) begin n_fail++; $display("FAIL sret idle busy got=%b exp=0", bus_v.o_busy); end
    tick();
  endtask

  task automatic test_priority_and_stall();
    int acks;
    acks = 0;
    trap_req = 1'b1; sret_req = 1'b1; trap_cause = 32'h2; trap_pc = 32'h80000040;
    trap_tval = 32'h0; trap_from_s = 1'b0; sstatus = 32'h0; stvec = 32'h80000100;
    sepc = 32'h80009000; instr_load = 1'b1; instr_sel = 12'h140; instr_data = 32'h00000055;
    settle();
    n_checks++; if (bus_v.o_ack !== 1'b1) begin n_fail++; $display("FAIL prio ack0 got=%b exp=1", bus_v.o_ack); end
    n_checks++; if ({bus_v.o_csr_load, bus_v.o_csr_select, bus_v.o_csr_data} !== {1'b1, 12'h140, 32'h00000055}) begin
      n_fail++; $display("FAIL prio instr_commit got=%b/%h/%h exp=1/140/00000055", bus_v.o_csr_load, bus_v.o_csr_select, bus_v.o_csr_data); end
    tick();
    trap_req = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      settle();
      if (bus_v.o_ack) acks++;
      n_checks++; if (bus_v.o_csr_load === 1'b1 && bus_v.o_csr_select === 12'h140) begin
        n_fail++; $display("FAIL stall instr_leak c%0d got=sel %h exp=not 140", c, bus_v.o_csr_select); end
      if (c == 1) begin
        n_checks++; if (bus_v.o_csr_select !== 12'h141) begin n_fail++; $display("FAIL prio trap_first got=%h exp=141", bus_v.o_csr_select); end
      end
      if (c == 5) begin
        n_checks++; if (bus_v.o_redirect_pc !== 32'h80000100) begin n_fail++; $display("FAIL prio trap_target got=%h exp=80000100", bus_v.o_redirect_pc); end
      end
      tick();
    end
    sret_req = 1'b0; instr_load = 1'b0;
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL busy_acks got=%0d exp=0", acks); end
    settle();
    n_checks++; if (bus_v.o_busy !== 1'b0 || bus_v.o_ack !== 1'b0) begin n_fail++; $display("FAIL prio idle got=%b/%b exp=0/0", bus_v.o_busy, bus_v.o_ack); end
    tick();
  endtask

  task automatic test_reset_abort();
    trap_req = 1'b1; trap_cause = 32'h7; trap_pc = 32'h80000500; trap_tval = 32'h1;
    trap_from_s = 1'b0; sstatus = 32'h2; stvec = 32'h80000100;
    tick();
    trap_req = 1'b0;
    tick();
    rst = 1'b1;
    settle();
    n_checks++; if (bus_v.o_csr_select !== 12'h142) begin n_fail++; $display("FAIL abort at_scause got=%h exp=142", bus_v.o_csr_select); end
    tick();
    rst = 1'b0;
    settle();
    n_checks++; if (bus_v.o_busy !== 1'b0) begin n_fail++; $display("FAIL abort busy got=%b exp=0", bus_v.o_busy); end
    n_checks++; if (bus_v.o_redirect_pc !== 32'h0) begin n_fail++; $display("FAIL abort rpc got=%h exp=0", bus_v.o_redirect_pc); end
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (bus_v.o_csr_load !== 1'b0 || bus_v.o_redirect_valid !== 1'b0) begin
        n_fail++; $display("FAIL abort quiet c%0d got=%b/%b exp=0/0", c, bus_v.o_csr_load, bus_v.o_redirect_valid); end
      tick();
      settle();
    end
    tick();
    run_trap("after_abort", 32'h0000000F, 32'h80000600, 32'h00000ABC, 1'b1,
             32'h00000000, 32'h80000100, 32'h00000100, 32'h80000100, 32'h80000100);
  endtask

  task automatic test_back_to_back();
    trap_req = 1'b1; trap_cause = 32'h80000001; trap_pc = 32'h80000700; trap_tval = 32'h0;
    trap_from_s = 1'b0; sstatus = 32'h0; stvec = 32'h80000101;
    for (int c = 0; c < 12; c++) begin
      settle();
      n_checks++; if (bus_v.o_ack !== ((c == 0) || (c == 6))) begin
        n_fail++; $display("FAIL b2b ack c%0d got=%b exp=%b", c, bus_v.o_ack, (c == 0) || (c == 6)); end
      n_checks++; if (bus_v.o_redirect_valid !== ((c == 5) || (c == 11))) begin
        n_fail++; $display("FAIL b2b rv c%0d got=%b exp=%b", c, bus_v.o_redirect_valid, (c == 5) || (c == 11)); end
      if (c == 5) begin
        n_checks++; if (bus_v.o_redirect_pc !== 32'h80000104) begin n_fail++; $display("FAIL b2b rpc got=%h exp=80000104", bus_v.o_redirect_pc); end
      end
      tick();
    end
    trap_req = 1'b0;
    settle();
    n_checks++; if (bus_v.o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b final busy got=%b exp=0", bus_v.o_busy); end
    tick();
  endtask

  initial begin
    test_reset();
    test_trap_direct();
    test_vectored();
    test_sret();
    test_priority_and_stall();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
